// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the register file writeback path.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_t;

    function automatic logic [NUM_REGS-1:0] onehot(input reg_addr_t a);
        return NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with its priority flop.
// Requester 0 maps to WB_ALU and requester 1 to WB_LSU.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    wb_src_t prio;

    // Grants are held low while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            if (req0 && (!req1 || prio == WB_ALU)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // After any grant, priority moves to the other requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= WB_LSU;
        end else if (gnt0) begin
            prio <= WB_LSU;
        end else if (gnt1) begin
            prio <= WB_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: arbitrates ALU/LSU writeback, registers the write
// and keeps the pending-write scoreboard. Optional bypass: REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                lsu_valid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_data,
    output logic                lsu_ready,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]   rf_rd_addr1,
    input  logic [ADDR_W-1:0]   rf_rd_addr2,
    input  logic [DATA_W-1:0]   rf_rd_data1,
    input  logic [DATA_W-1:0]   rf_rd_data2,
    output logic [DATA_W-1:0]   byp_data1,
    output logic [DATA_W-1:0]   byp_data2,
    output logic [NUM_REGS-1:0] busy_eff
`endif
);

    logic          any_gnt;
    reg_addr_t     sel_addr;
    reg_data_t     sel_data;
    logic [NUM_REGS-1:0] busy_nxt;

    rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (alu_valid),
        .req1 (lsu_valid),
        .gnt0 (alu_ready),
        .gnt1 (lsu_ready)
    );

    always_comb begin
        any_gnt  = alu_ready | lsu_ready;
        sel_addr = lsu_addr;
        sel_data = lsu_data;
        if (alu_ready) begin
            sel_addr = alu_addr;
            sel_data = alu_data;
        end
    end

    // A grant to x0 still completes the handshake but never raises wr_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= any_gnt && (sel_addr != '0);
            if (any_gnt) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    // Issue is applied after the clear so a same-cycle re-issue keeps the bit set.
    always_comb begin
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_nxt[issue_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    always_comb begin
        byp_data1 = rf_rd_data1;
        byp_data2 = rf_rd_data2;
        busy_eff  = busy;
        if (wr_en && wr_addr != '0) begin
            if (wr_addr == rf_rd_addr1) begin
                byp_data1 = wr_data;
            end
            if (wr_addr == rf_rd_addr2) begin
                byp_data2 = wr_data;
            end
        end
        if (wr_en) begin
            busy_eff = busy & ~onehot(wr_addr);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps then random traffic
// against a behavioural model of the arbitration, write pipeline and scoreboard.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_addr = '0;
    logic [31:0] lsu_data = '0;
    logic        lsu_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic [31:0] busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
`ifdef REGFILE_WB_BYPASS_EN
    logic [4:0]  rf_rd_addr1 = '0;
    logic [4:0]  rf_rd_addr2 = '0;
    logic [31:0] rf_rd_data1 = '0;
    logic [31:0] rf_rd_data2 = '0;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;
    logic [31:0] busy_eff;
`endif

    int checks   = 0;
    int failures = 0;

    bit          m_prio_lsu;
    logic [31:0] m_busy;
    bit          m_wr_en;
    logic [4:0]  m_wr_addr;
    logic [31:0] m_wr_data;
    bit          m_known;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_addr    (lsu_addr),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .busy        (busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_rd_addr2 (rf_rd_addr2),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .byp_data1   (byp_data1),
        .byp_data2   (byp_data2),
        .busy_eff    (busy_eff)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_prio_lsu = 1'b1;
        m_busy     = '0;
        m_wr_en    = 1'b0;
        m_wr_addr  = '0;
        m_wr_data  = '0;
        m_known    = 1'b1;
    endtask

    // One clock cycle: drive, check readies, advance model, check registered outputs.
    task automatic applyStimulus(
        input  bit av, input logic [4:0] aa, input logic [31:0] ad,
        input  bit lv, input logic [4:0] la, input logic [31:0] ld,
        input  bit iv, input logic [4:0] ia,
        output logic ra, output logic rl);
        bit          ga, gl;
        logic [31:0] nb;
        logic [4:0]  a;
        @(negedge clk);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        issue_valid = iv; issue_addr = ia;
        #1;
        ga = av && (!lv || !m_prio_lsu);
        gl = lv && !ga;
        ra = alu_ready;
        rl = lsu_ready;
        checkOutput("alu_ready", 32'(alu_ready), 32'(ga));
        checkOutput("lsu_ready", 32'(lsu_ready), 32'(gl));
        nb = m_busy;
        if (m_wr_en) nb = nb & ~(32'd1 << m_wr_addr);
        if (iv && ia != 5'd0) nb = nb | (32'd1 << ia);
        m_busy = nb;
        if (ga || gl) begin
            a          = ga ? aa : la;
            m_wr_en    = (a != 5'd0);
            m_known    = (a != 5'd0);
            m_wr_addr  = a;
            m_wr_data  = ga ? ad : ld;
            m_prio_lsu = ga;
        end else begin
            m_wr_en = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("wr_en", 32'(wr_en), 32'(m_wr_en));
        checkOutput("busy", busy, m_busy);
        if (m_known) begin
            checkOutput("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
            checkOutput("wr_data", wr_data, m_wr_data);
        end
    endtask

    initial begin
        logic ra, rl;
        bit   exp_lsu [4];
        bit   apend, lpend;
        logic [4:0]  aa, la;
        logic [31:0] ad, ld;

        modelReset();
        #12;
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", wr_data, 32'd0);
        checkOutput("rst_busy", busy, 32'd0);
        alu_valid = 1'b1;
        lsu_valid = 1'b1;
        #1;
        checkOutput("rst_alu_ready", 32'(alu_ready), 32'd0);
        checkOutput("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, ra, rl);
        checkOutput("single_ready", 32'(ra), 32'd1);
        checkOutput("single_wr_en", 32'(wr_en), 32'd1);
        checkOutput("single_wr_addr", 32'(wr_addr), 32'd5);
        checkOutput("single_wr_data", wr_data, 32'hDEADBEEF);

        exp_lsu = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 0, ra, rl);
            checkOutput("contend_lsu_ready", 32'(rl), 32'(exp_lsu[i]));
            checkOutput("contend_wr_addr", 32'(wr_addr), exp_lsu[i] ? 32'd4 : 32'd3);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, ra, rl);
        checkOutput("idle_hold_addr", 32'(wr_addr), 32'd3);

        applyStimulus(0, 0, 0, 1, 5'd0, 32'h99, 1, 5'd0, ra, rl);
        checkOutput("x0_ready", 32'(rl), 32'd1);
        checkOutput("x0_wr_en", 32'(wr_en), 32'd0);
        checkOutput("x0_busy0", 32'(busy[0]), 32'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, ra, rl);
        checkOutput("sb_set7", 32'(busy[7]), 32'd1);
        applyStimulus(1, 5'd7, 32'h77, 0, 0, 0, 0, 0, ra, rl);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, ra, rl);
        checkOutput("sb_set_wins", 32'(busy[7]), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd8, ra, rl);
        applyStimulus(0, 0, 0, 1, 5'd8, 32'h88, 0, 0, ra, rl);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, ra, rl);
        checkOutput("sb_clear8", 32'(busy[8]), 32'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd4, ra, rl);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, ra, rl);
        applyStimulus(1, 5'd1, 32'h55, 0, 0, 0, 1, 5'd6, ra, rl);
        checkOutput("pre_rst_busy", busy, 32'h0000_00F0);
        checkOutput("pre_rst_wr_en", 32'(wr_en), 32'd1);
        alu_valid = 1'b0;
        issue_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("async_rst_busy", busy, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 0, ra, rl);
        checkOutput("post_rst_lsu_first", 32'(rl), 32'd1);
        applyStimulus(1, 5'd3, 32'h11, 0, 0, 0, 0, 0, ra, rl);

        apend = 0; lpend = 0;
        aa = '0; la = '0; ad = '0; ld = '0;
        for (int i = 0; i < 400; i++) begin
            if (!apend) begin
                apend = ($urandom % 2) == 0;
                aa = 5'($urandom_range(1, 31));
                ad = $urandom;
            end
            if (!lpend) begin
                lpend = ($urandom % 2) == 0;
                la = 5'($urandom_range(1, 31));
                ld = $urandom;
            end
            applyStimulus(apend, aa, ad, lpend, la, ld,
                          ($urandom % 3) == 0, 5'($urandom_range(0, 31)), ra, rl);
            if (ra) apend = 0;
            if (rl) lpend = 0;
        end

`ifdef REGFILE_WB_BYPASS_EN
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, ra, rl);
        applyStimulus(1, 5'd9, 32'hABCD, 0, 0, 0, 0, 0, ra, rl);
        rf_rd_addr1 = 5'd9;
        rf_rd_data1 = 32'h0;
        rf_rd_addr2 = 5'd10;
        rf_rd_data2 = 32'h1234;
        #1;
        checkOutput("byp_data1", byp_data1, 32'hABCD);
        checkOutput("byp_data2", byp_data2, 32'h1234);
        checkOutput("busy9_raw", 32'(busy[9]), 32'd1);
        checkOutput("busy_eff9", 32'(busy_eff[9]), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
